// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator blocks (scheduler, movement FSM, 7-segment decoder).
package elevator_pkg;

    localparam int DEFAULT_NUM_FLOORS = 5;
    localparam int DEFAULT_FLOOR_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        DOOR
    } sched_state_t;

endpackage

// File: rtl/elevator_floor_selector.sv
// SCAN target picker: nearest pending floor in the travel direction, reversing only when
// nothing is left ahead.
module elevator_floor_selector
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W    = DEFAULT_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  dir_up,
    output logic [FLOOR_W-1:0]    target,
    output logic                  target_valid,
    output logic                  next_dir_up
);

    logic               above;
    logic               below;
    logic [FLOOR_W-1:0] above_floor;
    logic [FLOOR_W-1:0] below_floor;

    always_comb begin
        above       = 1'b0;
        below       = 1'b0;
        above_floor = '0;
        below_floor = '0;
        // Scan order makes the last match the nearest one on each side.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(current_floor))) begin
                above       = 1'b1;
                above_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(current_floor))) begin
                below       = 1'b1;
                below_floor = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        target       = '0;
        target_valid = 1'b0;
        next_dir_up  = dir_up;
        if (dir_up && above) begin
            target       = above_floor;
            target_valid = 1'b1;
            next_dir_up  = 1'b1;
        end else if (below) begin
            target       = below_floor;
            target_valid = 1'b1;
            next_dir_up  = 1'b0;
        end else if (above) begin
            target       = above_floor;
            target_valid = 1'b1;
            next_dir_up  = 1'b1;
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Latches call buttons, drives the SCAN target to the movement FSM and times the door dwell.
// The state output is a debug view of the scheduler FSM.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = DEFAULT_NUM_FLOORS,
    parameter int FLOOR_W      = DEFAULT_FLOOR_W,
    parameter int DWELL_CYCLES = 20000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_buttons,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  car_idle,
    output logic [FLOOR_W-1:0]    requested_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  dir_up,
    output sched_state_t          state
);

    localparam int                 DWELL_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

    sched_state_t          state_n;
    logic [FLOOR_W-1:0]    requested_n;
    logic [NUM_FLOORS-1:0] pending_n;
    logic                  door_n;
    logic                  dir_n;
    logic [DWELL_W-1:0]    dwell;
    logic [DWELL_W-1:0]    dwell_n;

    logic [NUM_FLOORS-1:0] cur_mask;
    logic                  cur_hit;
    logic [NUM_FLOORS-1:0] press_mask;
    logic [FLOOR_W-1:0]    sel_target;
    logic                  sel_valid;
    logic                  sel_dir;

    elevator_floor_selector #(
        .NUM_FLOORS(NUM_FLOORS),
        .FLOOR_W   (FLOOR_W)
    ) u_selector (
        .pending      (pending),
        .current_floor(current_floor),
        .dir_up       (dir_up),
        .target       (sel_target),
        .target_valid (sel_valid),
        .next_dir_up  (sel_dir)
    );

    // Out-of-range floors produce an all-zero mask, i.e. no request bit.
    always_comb begin
        cur_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cur_mask[i] = (int'(current_floor) == i);
        end
    end

    assign cur_hit    = |(pending & cur_mask);
    assign press_mask = (state == DOOR) ? ~cur_mask : '1;

    always_comb begin
        state_n     = state;
        requested_n = requested_floor;
        door_n      = door_open;
        dir_n       = dir_up;
        dwell_n     = dwell;
        pending_n   = pending | (call_buttons & press_mask);

        case (state)
            IDLE: begin
                if (cur_hit) begin
                    state_n     = DOOR;
                    pending_n   = pending_n & ~cur_mask;
                    door_n      = 1'b1;
                    dwell_n     = DWELL_LOAD;
                    requested_n = current_floor;
                end else if (sel_valid) begin
                    state_n     = SERVE;
                    requested_n = sel_target;
                    dir_n       = sel_dir;
                end else begin
                    requested_n = current_floor;
                end
            end
            SERVE: begin
                // The clear wins over a same-cycle press at the arrival floor.
                if (car_idle && (current_floor == requested_floor) && cur_hit) begin
                    state_n     = DOOR;
                    pending_n   = pending_n & ~cur_mask;
                    door_n      = 1'b1;
                    dwell_n     = DWELL_LOAD;
                    requested_n = current_floor;
                end else if (sel_valid) begin
                    requested_n = sel_target;
                    dir_n       = sel_dir;
                end else if (pending == '0) begin
                    state_n     = IDLE;
                    requested_n = current_floor;
                end
            end
            DOOR: begin
                requested_n = current_floor;
                if (dwell == '0) begin
                    door_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    dwell_n = dwell - DWELL_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            requested_floor <= '0;
            pending         <= '0;
            door_open       <= 1'b0;
            dir_up          <= 1'b1;
            dwell           <= '0;
        end else begin
            state           <= state_n;
            requested_floor <= requested_n;
            pending         <= pending_n;
            door_open       <= door_n;
            dir_up          <= dir_n;
            dwell           <= dwell_n;
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for the request scheduler with a short dwell; served floors are tracked in order.
module tb_elevator_request_scheduler;
    import elevator_pkg::*;

    logic         clk;
    logic         rst;
    logic [4:0]   call_buttons;
    logic [3:0]   current_floor;
    logic         car_idle;
    logic [3:0]   requested_floor;
    logic [4:0]   pending;
    logic         door_open;
    logic         dir_up;
    sched_state_t state;

    int         checks   = 0;
    int         failures = 0;
    int         n;
    logic [3:0] exp_q[$];
    logic [3:0] exp_floor;
    logic       door_q;

    elevator_request_scheduler #(
        .NUM_FLOORS  (5),
        .FLOOR_W     (4),
        .DWELL_CYCLES(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .call_buttons   (call_buttons),
        .current_floor  (current_floor),
        .car_idle       (car_idle),
        .requested_floor(requested_floor),
        .pending        (pending),
        .door_open      (door_open),
        .dir_up         (dir_up),
        .state          (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change on the falling edge, outputs are read there too.
    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] mask);
        call_buttons = mask;
        @(negedge clk);
        call_buttons = '0;
    endtask

    task automatic do_reset(input logic [3:0] floor);
        rst           = 1'b1;
        call_buttons  = '0;
        current_floor = floor;
        car_idle      = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic door_len(output int len);
        len = 0;
        while (door_open && len < 50) begin
            len++;
            tick(1);
        end
        if (door_open) check("door_timeout", door_open, 0);
    endtask

    // Scoreboard: each door opening must happen at the next expected floor.
    always @(posedge clk) begin
        #1;
        if (!rst && door_open && !door_q) begin
            if (exp_q.size() == 0) begin
                check("serve_unexpected", current_floor, 4'hF);
            end else begin
                exp_floor = exp_q.pop_front();
                check("serve_floor", current_floor, exp_floor);
            end
        end
        door_q <= door_open;
    end

    initial begin
        rst           = 1'b1;
        call_buttons  = '0;
        current_floor = '0;
        car_idle      = 1'b1;
        tick(2);
        check("rst_req", requested_floor, 0);
        check("rst_pending", pending, 0);
        check("rst_door", door_open, 0);
        check("rst_dir", dir_up, 1);
        check("rst_state", state, IDLE);
        rst = 1'b0;

        // Single call, full dwell
        press(5'b00100);
        check("t1_pending", pending, 5'b00100);
        check("t1_req_early", requested_floor, 0);
        check("t1_state_idle", state, IDLE);
        tick(1);
        check("t1_req", requested_floor, 2);
        check("t1_state_serve", state, SERVE);
        check("t1_dir", dir_up, 1);
        exp_q.push_back(4'd2);
        current_floor = 4'd2;
        tick(1);
        check("t1_door", door_open, 1);
        check("t1_cleared", pending, 0);
        check("t1_state_door", state, DOOR);
        door_len(n);
        check("t1_door_len", n, 4);
        check("t1_back_idle", state, IDLE);

        // SCAN order: up through 3 and 4, then reverse to 1
        do_reset(4'd0);
        press(5'b11000);
        check("t2_pending", pending, 5'b11000);
        tick(1);
        check("t2_req3", requested_floor, 3);
        check("t2_dir_up", dir_up, 1);
        current_floor = 4'd1;
        tick(1);
        check("t2_req3_travel", requested_floor, 3);
        exp_q.push_back(4'd3);
        current_floor = 4'd3;
        tick(1);
        check("t2_pending_after3", pending, 5'b10000);
        door_len(n);
        check("t2_door_len", n, 4);
        tick(1);
        check("t2_req4", requested_floor, 4);
        press(5'b00010);
        check("t2_req4_hold", requested_floor, 4);
        check("t2_pending_1", pending, 5'b10010);
        check("t2_dir_still_up", dir_up, 1);
        exp_q.push_back(4'd4);
        current_floor = 4'd4;
        tick(1);
        check("t2_pending_after4", pending, 5'b00010);
        door_len(n);
        tick(1);
        check("t2_req1", requested_floor, 1);
        check("t2_dir_down", dir_up, 0);
        exp_q.push_back(4'd1);
        current_floor = 4'd1;
        tick(1);
        door_len(n);
        check("t2_all_served", pending, 0);

        // Retarget to a nearer floor pressed in the travel direction
        press(5'b10000);
        check("t3_pending", pending, 5'b10000);
        tick(1);
        check("t3_req4", requested_floor, 4);
        check("t3_dir_up", dir_up, 1);
        press(5'b00100);
        check("t3_req4_hold", requested_floor, 4);
        tick(1);
        check("t3_retarget", requested_floor, 2);
        check("t3_pending_kept", pending, 5'b10100);

        // Call at the current floor while idle opens the door in place
        do_reset(4'd3);
        tick(1);
        check("t5_idle_hold", requested_floor, 3);
        press(5'b01000);
        check("t5_pending", pending, 5'b01000);
        check("t5_state_idle", state, IDLE);
        exp_q.push_back(4'd3);
        tick(1);
        check("t5_state_door", state, DOOR);
        check("t5_door", door_open, 1);
        check("t5_req", requested_floor, 3);
        check("t5_cleared", pending, 0);

        // Presses during the door: own floor ignored, other floor latched
        press(5'b01000);
        check("t4_own_masked", pending, 0);
        press(5'b00010);
        check("t4_other_latched", pending, 5'b00010);
        check("t4_door_still", door_open, 1);
        door_len(n);
        check("t4_req_held", requested_floor, 3);

        // Reset in the middle of a dwell
        do_reset(4'd0);
        press(5'b00001);
        exp_q.push_back(4'd0);
        tick(1);
        press(5'b01010);
        check("t6_pending", pending, 5'b01010);
        check("t6_door", door_open, 1);
        rst = 1'b1;
        tick(1);
        check("t6_req", requested_floor, 0);
        check("t6_pending_rst", pending, 0);
        check("t6_door_rst", door_open, 0);
        check("t6_dir_rst", dir_up, 1);
        check("t6_state_rst", state, IDLE);
        rst = 1'b0;
        tick(2);

        check("serve_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
